// File: rtl/a4092_irq_pkg.sv
// a4092_irq_pkg
// Shared definitions for the NCR 53C710 interrupt conditioning path.
// Contents:
//   irq_state_t      conditioner FSM states (IDLE, QUAL, ASSERTED, HOLDOFF)
//   DEF_*            default synchroniser / filter / re-arm lengths
//   STAT_WIDTH       width of the optional statistics counters
//   max_int          constant helper used for sizing the shared counter
package a4092_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        ASSERTED = 2'd2,
        HOLDOFF  = 2'd3
    } irq_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_REARM_CYCLES  = 16;
    localparam int STAT_WIDTH        = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync
// N-stage flip-flop synchroniser for a single asynchronous board input.
// Ports:
//   clk  in   sampling clock
//   rst  in   asynchronous, active-high reset (all stages to 0)
//   d    in   asynchronous input
//   q    out  synchronised copy of d, STAGES clocks late
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("irq_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/ncr_irq_conditioner.sv
// ncr_irq_conditioner
// Synchronises and glitch-filters the NCR 53C710 IRQ_n line and produces a
// single-cycle NCR_INT pulse per qualified interrupt. After a host
// acknowledge the pulse is re-issued if the chip still holds the line low
// once a holdoff period has elapsed.
// Ports:
//   CLK         in   system clock
//   RESET       in   asynchronous, active-high reset
//   NCR_IRQ_n   in   raw asynchronous interrupt, active low
//   IRQ_ENABLE  in   board interrupt enable; low forces IDLE
//   INT_ACK     in   one-cycle pulse when the host clears INTREG
//   NCR_INT     out  registered one-cycle qualified-interrupt pulse
//   irq_level   out  filtered level, high in ASSERTED or HOLDOFF
//   glitch_cnt  out  saturating count of rejected glitches
//   irq_cnt     out  wrapping count of emitted pulses
// Build option: define IRQ_STATS_EN to implement glitch_cnt / irq_cnt;
// otherwise both read as zero and no counter flops exist.
module ncr_irq_conditioner
    import a4092_irq_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int REARM_CYCLES  = DEF_REARM_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  NCR_IRQ_n,
    input  logic                  IRQ_ENABLE,
    input  logic                  INT_ACK,
    output logic                  NCR_INT,
    output logic                  irq_level,
    output logic [STAT_WIDTH-1:0] glitch_cnt,
    output logic [STAT_WIDTH-1:0] irq_cnt
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ncr_irq_conditioner: SYNC_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 2) begin : g_bad_filter
        $error("ncr_irq_conditioner: FILTER_CYCLES must be at least 2");
    end
    if (REARM_CYCLES < 2) begin : g_bad_rearm
        $error("ncr_irq_conditioner: REARM_CYCLES must be at least 2");
    end

    // One counter serves both the qualification window and the holdoff.
    localparam int CW = $clog2(max_int(FILTER_CYCLES, REARM_CYCLES));
    localparam logic [CW-1:0] FILT_LAST  = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] REARM_LAST = CW'(REARM_CYCLES - 1);

    logic          irq_s;
    irq_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          int_nxt;

    // The line is inverted before synchronising so that reset (all zeros)
    // reads as "no interrupt".
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (~NCR_IRQ_n),
        .q   (irq_s)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            NCR_INT <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            NCR_INT <= int_nxt;
        end
    end

    // Disable overrides everything, including the edge that would enter
    // ASSERTED, but leaves the counter untouched. In ASSERTED a release is
    // checked before INT_ACK so a simultaneous release wins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        int_nxt   = 1'b0;
        if (!IRQ_ENABLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (irq_s) begin
                        state_nxt = QUAL;
                        cnt_nxt   = CW'(1);
                    end
                end
                QUAL: begin
                    if (!irq_s) begin
                        state_nxt = IDLE;
                    end else if (cnt == FILT_LAST) begin
                        state_nxt = ASSERTED;
                        int_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ASSERTED: begin
                    if (!irq_s) begin
                        state_nxt = IDLE;
                    end else if (INT_ACK) begin
                        state_nxt = HOLDOFF;
                        cnt_nxt   = '0;
                    end
                end
                HOLDOFF: begin
                    if (!irq_s) begin
                        state_nxt = IDLE;
                    end else if (cnt == REARM_LAST) begin
                        state_nxt = ASSERTED;
                        int_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign irq_level = (state == ASSERTED) || (state == HOLDOFF);

`ifdef IRQ_STATS_EN
    // A glitch is a qualification abandoned because the line went away;
    // an abort forced by IRQ_ENABLE is not counted.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            glitch_cnt <= '0;
            irq_cnt    <= '0;
        end else begin
            if (IRQ_ENABLE && (state == QUAL) && !irq_s && (glitch_cnt != '1)) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
            if (int_nxt) begin
                irq_cnt <= irq_cnt + 1'b1;
            end
        end
    end
`else
    assign glitch_cnt = '0;
    assign irq_cnt    = '0;
`endif

endmodule

// File: tb/tb_ncr_irq_conditioner.sv
// tb_ncr_irq_conditioner
// Scoreboarded bench for ncr_irq_conditioner with default parameters.
// The reference model tracks, per clock edge, the length of the current
// unbroken run of "synchronised line asserted and enabled" samples and the
// time since an accepted acknowledge; pulses are predicted from those.
module tb_ncr_irq_conditioner;

    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int REARM = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       NCR_IRQ_n;
    logic       IRQ_ENABLE;
    logic       INT_ACK;
    logic       NCR_INT;
    logic       irq_level;
    logic [7:0] glitch_cnt;
    logic [7:0] irq_cnt;

    int errors   = 0;
    int checks   = 0;
    int edge_cnt = 0;

    typedef struct {
        int edge_no;
        int cnt;
    } pulse_t;

    pulse_t exp_q[$];

    // reference model state
    logic [SYNC-1:0] hist;
    int run;
    int hold;
    int m_glitch;
    int m_irq;

    ncr_irq_conditioner dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .NCR_IRQ_n  (NCR_IRQ_n),
        .IRQ_ENABLE (IRQ_ENABLE),
        .INT_ACK    (INT_ACK),
        .NCR_INT    (NCR_INT),
        .irq_level  (irq_level),
        .glitch_cnt (glitch_cnt),
        .irq_cnt    (irq_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int stat_glitch();
`ifdef IRQ_STATS_EN
        return m_glitch;
`else
        return 0;
`endif
    endfunction

    function automatic int stat_irq();
`ifdef IRQ_STATS_EN
        return m_irq;
`else
        return 0;
`endif
    endfunction

    // Advances the model by one clock edge given the inputs present there.
    task automatic modelStep(input logic raw_n, input logic en, input logic ack, output bit pulse);
        logic s;
        s     = hist[SYNC-1];
        hist  = {hist[SYNC-2:0], ~raw_n};
        pulse = 1'b0;
        if (!(s && en)) begin
            if (en && !s && run >= 1 && run < FILT && m_glitch < 255) m_glitch++;
            run  = 0;
            hold = -1;
        end else begin
            run++;
            if (run == FILT) begin
                pulse = 1'b1;
            end else if (run > FILT) begin
                if (hold < 0) begin
                    if (ack) hold = 0;
                end else begin
                    hold++;
                    if (hold == REARM) begin
                        pulse = 1'b1;
                        hold  = -1;
                    end
                end
            end
        end
        if (pulse) m_irq = (m_irq + 1) % 256;
    endtask

    // Drives one clock's worth of inputs, records any predicted pulse, and
    // checks the level and statistics outputs after the edge.
    task automatic applyStimulus(input logic raw_n, input logic en, input logic ack);
        bit     pulse;
        pulse_t p;
        NCR_IRQ_n  = raw_n;
        IRQ_ENABLE = en;
        INT_ACK    = ack;
        modelStep(raw_n, en, ack, pulse);
        if (pulse) begin
            p.edge_no = edge_cnt + 1;
            p.cnt     = stat_irq();
            exp_q.push_back(p);
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("irq_level", int'(irq_level), (run >= FILT) ? 1 : 0);
        checkOutput("glitch_cnt", int'(glitch_cnt), stat_glitch());
        checkOutput("irq_cnt", int'(irq_cnt), stat_irq());
    endtask

    task automatic applyReset(input logic raw_n);
        RESET     = 1'b1;
        NCR_IRQ_n = raw_n;
        INT_ACK   = 1'b0;
        #1;
        checkOutput("reset NCR_INT", int'(NCR_INT), 0);
        checkOutput("reset irq_level", int'(irq_level), 0);
        checkOutput("reset glitch_cnt", int'(glitch_cnt), 0);
        checkOutput("reset irq_cnt", int'(irq_cnt), 0);
        hist     = '0;
        run      = 0;
        hold     = -1;
        m_glitch = 0;
        m_irq    = 0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic idleLine(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: every NCR_INT pulse must match the head of the scoreboard,
    // and an expected pulse that never appears is reported as missed.
    always @(negedge CLK) begin
        pulse_t p;
        if (NCR_INT === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected NCR_INT pulse", 1, 0);
            end else begin
                p = exp_q.pop_front();
                checkOutput("pulse edge", edge_cnt, p.edge_no);
                checkOutput("pulse irq_cnt", int'(irq_cnt), p.cnt);
            end
        end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
            p = exp_q.pop_front();
            checkOutput("missed NCR_INT pulse at edge", edge_cnt, -p.edge_no);
        end
    end

    initial begin
        IRQ_ENABLE = 1'b1;
        applyReset(1'b1);
        idleLine(4);

        // 1: latency from first low capture (edge 0) to pulse after edge 5
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("t1 NCR_INT", int'(NCR_INT), (i == 5) ? 1 : 0);
        end
        checkOutput("t1 irq_level", int'(irq_level), 1);
        idleLine(4);

        // 2: glitches, repeated past the saturation point
        for (int g = 0; g < 300; g++) begin
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
            idleLine(4);
        end
`ifdef IRQ_STATS_EN
        checkOutput("t2 glitch_cnt saturated", int'(glitch_cnt), 255);
`else
        checkOutput("t2 glitch_cnt tied", int'(glitch_cnt), 0);
`endif

        // 3a: acknowledge with line still low -> re-pulse 16 edges later
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("t3 rearm NCR_INT", int'(NCR_INT), (k == 16) ? 1 : 0);
        end
        idleLine(5);

        // 3b: release during holdoff -> no second pulse
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t3b irq_level", int'(irq_level), 0);

        // 4: release together with INT_ACK
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4 irq_level released", int'(irq_level), 0);
        idleLine(20);

        // 5: enable gating
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 disabled irq_level", int'(irq_level), 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
                seen += int'(NCR_INT);
            end
            checkOutput("t5 pulses after enable", seen, 1);
        end
        idleLine(5);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 qualifying edge disabled", int'(NCR_INT), 0);
        idleLine(5);

        // 6: asynchronous reset in HOLDOFF, then full requalification
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        #2;
        applyReset(1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("t6 requalify NCR_INT", int'(NCR_INT), (i == 5) ? 1 : 0);
        end
        idleLine(5);

        // random traffic against the model
        begin
            logic raw_n, en;
            int   seg;
            raw_n = 1'b1;
            en    = 1'b1;
            seg   = 0;
            for (int i = 0; i < 1500; i++) begin
                if (seg == 0) begin
                    raw_n = ~raw_n;
                    seg   = $urandom_range(1, 24);
                end
                seg--;
                en = ($urandom_range(0, 19) != 0);
                applyStimulus(raw_n, en, ($urandom_range(0, 5) == 0));
            end
        end
        idleLine(6);

        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
